bcd_display_scanner: RTL and testbench

Time-multiplexed three-digit seven-segment driver that sits directly downstream of the binary-to-BCD converter. It captures the 12-bit packed BCD value (hundreds, tens, ones) on a load strobe into a shadow register. It then scans the three digits onto a shared active-low segment bus with active-low digit enables, with optional leading-zero blanking and a dash for invalid BCD nibbles.

---
 rtl/bcd_display_scanner.sv | 141 ++++++++++++++
 tb/tb_bcd_display_scanner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// Three-digit multiplexed seven-segment driver: captures packed BCD into a shadow
// register and scans hundreds/tens/ones onto active-low segment and digit-enable pins.
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [11:0] bcd_in,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        invalid
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    DIG_ONES     = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2
  } digit_t;

  logic [11:0]   shadow;
  logic [CW-1:0] cnt;
  digit_t        idx;
  digit_t        idx_next;
  logic          slot_end;
  logic [3:0]    hundreds;
  logic [3:0]    tens;
  logic [3:0]    ones;
  logic [3:0]    nibble;
  logic          blanked;
  logic [6:0]    seg_next;
  logic [2:0]    an_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  function automatic logic bad_nibble(input logic [3:0] d);
    return d > 4'd9;
  endfunction

  // Capture path; the invalid flag follows the incoming value on the capture edge itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= '0;
      invalid <= 1'b0;
    end else if (load) begin
      shadow  <= bcd_in;
      invalid <= bad_nibble(bcd_in[11:8]) | bad_nibble(bcd_in[7:4]) | bad_nibble(bcd_in[3:0]);
    end
  end

  assign slot_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= DIG_ONES;
    end else begin
      idx <= idx_next;
    end
  end

  always_comb begin
    idx_next = idx;
    if (slot_end) begin
      case (idx)
        DIG_ONES:     idx_next = DIG_TENS;
        DIG_TENS:     idx_next = DIG_HUNDREDS;
        default:      idx_next = DIG_ONES;
      endcase
    end
  end

  assign hundreds = shadow[11:8];
  assign tens     = shadow[7:4];
  assign ones     = shadow[3:0];

  // Invalid nibbles are nonzero, so they naturally stop leading-zero suppression.
  always_comb begin
    nibble  = ones;
    blanked = 1'b0;
    an_next = 3'b110;
    case (idx)
      DIG_TENS: begin
        nibble  = tens;
        blanked = blank_lz && (hundreds == 4'd0) && (tens == 4'd0);
        an_next = 3'b101;
      end
      DIG_HUNDREDS: begin
        nibble  = hundreds;
        blanked = blank_lz && (hundreds == 4'd0);
        an_next = 3'b011;
      end
      default: begin
        nibble  = ones;
        blanked = 1'b0;
        an_next = 3'b110;
      end
    endcase
    seg_next = blanked ? 7'h7F : decode(nibble);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= 7'h7F;
      an  <= 3'b111;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner with REFRESH_DIV=4: stimulus queues expected
// pin values tagged with an edge number, a negedge monitor pops and compares them.
module tb_bcd_display_scanner;

  logic        clk;
  logic        reset;
  logic        load;
  logic [11:0] bcd_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        invalid;

  typedef struct {
    int         cyc;
    logic [2:0] an;
    logic [6:0] seg;
    logic       inv;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   edges = 0;
  int   tests = 0;
  int   fails = 0;

  bcd_display_scanner #(.REFRESH_DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .bcd_in(bcd_in),
    .blank_lz(blank_lz),
    .seg(seg),
    .an(an),
    .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge count since reset release; expectations are keyed to it.
  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= edges) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      if (e.cyc < edges) begin
        fails++;
        $display("[TB] FAIL %s: expectation for edge %0d missed (now edge %0d)", e.name, e.cyc, edges);
      end else if (an !== e.an || seg !== e.seg || invalid !== e.inv) begin
        fails++;
        $display("[TB] FAIL %s @edge %0d: got an=%b seg=%h invalid=%b, want an=%b seg=%h invalid=%b",
                 e.name, edges, an, seg, invalid, e.an, e.seg, e.inv);
      end
    end
  end

  task automatic expectAt(input int cyc, input logic [2:0] a, input logic [6:0] s,
                          input logic inv, input string name);
    exp_t e;
    e.cyc = cyc; e.an = a; e.seg = s; e.inv = inv; e.name = name;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic doReset();
    drain();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic loadValue(input logic [11:0] v);
    load   = 1'b1;
    bcd_in = v;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic waitEdges(input int n);
    for (int i = 0; i < 1000 && edges < n; i++) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    bcd_in   = '0;
    blank_lz = 1'b0;
    expectAt(0, 3'b111, 7'h7F, 1'b0, "reset_values");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset sequence and mid-slot asynchronous reset
    expectAt(1, 3'b110, 7'h40, 1'b0, "rst_first_edge");
    expectAt(4, 3'b110, 7'h40, 1'b0, "rst_ones_hold");
    expectAt(5, 3'b101, 7'h40, 1'b0, "rst_tens_edge5");
    expectAt(6, 3'b101, 7'h40, 1'b0, "rst_tens_mid");
    waitEdges(6);
    @(posedge clk);
    #2;
    reset = 1'b1;
    expectAt(0, 3'b111, 7'h7F, 1'b0, "rst_async_midslot");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    expectAt(1, 3'b110, 7'h40, 1'b0, "rst2_first_edge");
    expectAt(5, 3'b101, 7'h40, 1'b0, "rst2_edge5");
    expectAt(9, 3'b011, 7'h40, 1'b0, "rst2_edge9");

    // Plain scan of 251
    doReset();
    blank_lz = 1'b0;
    loadValue(12'h251);
    expectAt(1,  3'b110, 7'h40, 1'b0, "scan_old_shadow");
    expectAt(2,  3'b110, 7'h79, 1'b0, "scan_ones");
    expectAt(5,  3'b101, 7'h12, 1'b0, "scan_tens");
    expectAt(9,  3'b011, 7'h24, 1'b0, "scan_hundreds");
    expectAt(13, 3'b110, 7'h79, 1'b0, "scan_ones_again");

    // Leading-zero blanking of 007, then blanking turned off
    doReset();
    blank_lz = 1'b1;
    loadValue(12'h007);
    expectAt(2,  3'b110, 7'h78, 1'b0, "blank_ones");
    expectAt(5,  3'b101, 7'h7F, 1'b0, "blank_tens");
    expectAt(9,  3'b011, 7'h7F, 1'b0, "blank_hundreds");
    expectAt(13, 3'b110, 7'h78, 1'b0, "noblank_ones");
    expectAt(17, 3'b101, 7'h40, 1'b0, "noblank_tens");
    expectAt(21, 3'b011, 7'h40, 1'b0, "noblank_hundreds");
    waitEdges(12);
    blank_lz = 1'b0;

    // Invalid nibble, then a valid value with interior zeros
    doReset();
    blank_lz = 1'b1;
    loadValue(12'h0A3);
    expectAt(1,  3'b110, 7'h40, 1'b1, "inv_capture_edge");
    expectAt(2,  3'b110, 7'h30, 1'b1, "inv_ones");
    expectAt(5,  3'b101, 7'h3F, 1'b1, "inv_tens_dash");
    expectAt(9,  3'b011, 7'h7F, 1'b1, "inv_hundreds_blank");
    expectAt(13, 3'b110, 7'h30, 1'b0, "inv_cleared");
    expectAt(14, 3'b110, 7'h40, 1'b0, "val100_ones");
    expectAt(17, 3'b101, 7'h40, 1'b0, "val100_tens_shown");
    expectAt(21, 3'b011, 7'h79, 1'b0, "val100_hundreds");
    waitEdges(12);
    loadValue(12'h100);

    // Mid-slot load during the ones slot at cnt=1
    doReset();
    blank_lz = 1'b0;
    loadValue(12'h005);
    expectAt(13, 3'b110, 7'h12, 1'b0, "mid_before");
    expectAt(14, 3'b110, 7'h12, 1'b0, "mid_capture_edge");
    expectAt(15, 3'b110, 7'h10, 1'b0, "mid_new_value");
    expectAt(16, 3'b110, 7'h10, 1'b0, "mid_slot_kept");
    expectAt(17, 3'b101, 7'h40, 1'b0, "mid_boundary");
    waitEdges(13);
    loadValue(12'h009);

    // Load coinciding with the slot wrap
    doReset();
    expectAt(4,  3'b110, 7'h40, 1'b0, "wrap_capture_edge");
    expectAt(5,  3'b101, 7'h24, 1'b0, "wrap_tens");
    expectAt(9,  3'b011, 7'h79, 1'b0, "wrap_hundreds");
    expectAt(13, 3'b110, 7'h30, 1'b0, "wrap_ones");
    waitEdges(3);
    loadValue(12'h123);

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "[TB] watchdog");
  end

endmodule
